// File: rtl/sdm_pkg.sv
// Shared constants and helpers for the MASH sigma-delta modulator:
// output offset per order, dither LFSR definition and thermometer encoder.
package sdm_pkg;

  localparam logic [14:0] LFSR_TAPS = 15'h6000; // x^15 + x^14 + 1
  localparam logic [14:0] LFSR_SEED = 15'h0001;

  // Offset that makes the combiner sum non-negative for order n.
  function automatic logic [2:0] off_of(input logic [1:0] n);
    case (n)
      2'd2:    off_of = 3'd1;
      2'd3:    off_of = 3'd3;
      default: off_of = 3'd0;
    endcase
  endfunction

  function automatic logic [6:0] thrm_encode(input logic [2:0] lvl);
    logic [6:0] t;
    t = 7'd0;
    for (int i = 0; i < 7; i++) begin
      t[i] = (3'(i) < lvl);
    end
    return t;
  endfunction

endpackage

// File: rtl/sdm_acc_stage.sv
// One first-order accumulator stage; the carry out is the stage's quantiser output.
module sdm_acc_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         active,
  input  logic         cin,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] frac_o,
  output logic         carry_o
);

  logic [W:0] acc_q;
  logic [W:0] acc_d;

  always_comb begin
    if (clr || !active) begin
      acc_d = '0;
    end else begin
      acc_d = {1'b0, in_i} + {1'b0, acc_q[W-1:0]} + {{W{1'b0}}, cin};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign frac_o  = acc_q[W-1:0];
  assign carry_o = acc_q[W];

endmodule

// File: rtl/sdm_mash.sv
// MASH 1-1-1 sigma-delta modulator with selectable order, optional LFSR dither
// and binary or thermometer registered output.
module sdm_mash
  import sdm_pkg::*;
#(
  parameter int W         = 8,
  parameter int ORDER_MAX = 3
) (
  input  logic                         nsh_clk,
  input  logic                         nsh_rst_n,
  input  logic [W-1:0]                 s_os,
  input  logic                         csr_flb_sdm_en,
  input  logic [1:0]                   csr_flb_sdm_order,
  input  logic                         csr_flb_sdm_thrm_en,
  input  logic                         csr_flb_sdm_dither_en,
  output logic [ORDER_MAX-1:0]         os_bin,
  output logic [(2**ORDER_MAX)-2:0]    os_thrm
);

  localparam logic [1:0] ORD_MAX = 2'(ORDER_MAX);
  localparam int         TW      = (2**ORDER_MAX) - 1;

  logic [1:0]                  ord_nz;
  logic [1:0]                  ord_eff;
  logic [1:0]                  order_q;
  logic                        chg;
  logic                        clr;
  logic [14:0]                 lfsr_q;
  logic [14:0]                 lfsr_d;
  logic [2:0]                  cur_c;
  logic [2:0]                  d1_q;
  logic [2:0]                  d1_d;
  logic [2:0]                  d2_q;
  logic [2:0]                  d2_d;
  logic [2:0]                  pos;
  logic [2:0]                  neg;
  logic [2:0]                  lvl;
  logic [6:0]                  thrm_full;
  logic [ORDER_MAX-1:0]        os_bin_d;
  logic [TW-1:0]               os_thrm_d;
  logic [ORDER_MAX-1:0]        carry_s;
  logic [ORDER_MAX:0][W-1:0]   frac_s;
  logic [W-1:0]                frac_last_unused;

  always_comb begin
    ord_nz  = (csr_flb_sdm_order == 2'd0) ? 2'd1 : csr_flb_sdm_order;
    ord_eff = (ord_nz < ORD_MAX) ? ord_nz : ORD_MAX;
  end

  // order_q == 0 only after reset, so the first enabled edge is never seen as a change
  assign chg = csr_flb_sdm_en && (order_q != 2'd0) && (order_q != ord_eff);
  assign clr = !csr_flb_sdm_en || chg;

  assign frac_s[0]        = s_os;
  assign frac_last_unused = frac_s[ORDER_MAX];

  genvar k;
  generate
    for (k = 0; k < ORDER_MAX; k++) begin : g_stage
      localparam logic [1:0] KIDX = 2'(k + 1);
      sdm_acc_stage #(.W(W)) u_stage (
        .clk     (nsh_clk),
        .rst_n   (nsh_rst_n),
        .clr     (clr),
        .active  (KIDX <= ord_eff),
        .cin     ((KIDX == ord_eff) && csr_flb_sdm_dither_en && lfsr_q[0]),
        .in_i    (frac_s[k]),
        .frac_o  (frac_s[k+1]),
        .carry_o (carry_s[k])
      );
    end
    for (k = 0; k < 3; k++) begin : g_carry
      if (k < ORDER_MAX) begin : g_live
        assign cur_c[k] = carry_s[k];
      end else begin : g_pad
        assign cur_c[k] = 1'b0;
      end
    end
  endgenerate

  // Noise-cancelling combiner; 3-bit modular arithmetic is exact since the level is 0..7.
  always_comb begin
    case (ord_eff)
      2'd2: begin
        pos = {2'b00, d1_q[0]} + {2'b00, cur_c[1]};
        neg = {2'b00, d1_q[1]};
      end
      2'd3: begin
        pos = {2'b00, d2_q[0]} + {2'b00, d1_q[1]} + {2'b00, cur_c[2]} + {2'b00, d2_q[2]};
        neg = {2'b00, d2_q[1]} + {1'b0, d1_q[2], 1'b0};
      end
      default: begin
        pos = {2'b00, cur_c[0]};
        neg = 3'd0;
      end
    endcase
    if (chg) begin
      lvl = off_of(ord_eff);
    end else begin
      lvl = off_of(ord_eff) + pos - neg;
    end
    thrm_full = thrm_encode(lvl);
  end

  always_comb begin
    lfsr_d = csr_flb_sdm_en ? {lfsr_q[13:0], ^(lfsr_q & LFSR_TAPS)} : LFSR_SEED;
    d1_d   = clr ? 3'd0 : cur_c;
    d2_d   = clr ? 3'd0 : d1_q;
    if (!csr_flb_sdm_en) begin
      os_bin_d  = '0;
      os_thrm_d = '0;
    end else if (csr_flb_sdm_thrm_en) begin
      os_bin_d  = '0;
      os_thrm_d = thrm_full[TW-1:0];
    end else begin
      os_bin_d  = lvl[ORDER_MAX-1:0];
      os_thrm_d = '0;
    end
  end

  always_ff @(posedge nsh_clk or negedge nsh_rst_n) begin
    if (!nsh_rst_n) begin
      order_q <= 2'd0;
      lfsr_q  <= LFSR_SEED;
      d1_q    <= 3'd0;
      d2_q    <= 3'd0;
      os_bin  <= '0;
      os_thrm <= '0;
    end else begin
      order_q <= ord_eff;
      lfsr_q  <= lfsr_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      os_bin  <= os_bin_d;
      os_thrm <= os_thrm_d;
    end
  end

endmodule

// File: tb/tb_sdm_mash.sv
// Directed, table-driven bench for sdm_mash (W=8, ORDER_MAX=3) with hand-computed
// expected levels plus sequences for means, order switching, reset and dither reseed.
module tb_sdm_mash;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_os;
  logic       en;
  logic [1:0] ord;
  logic       thrm;
  logic       dith;
  logic [2:0] os_bin;
  logic [6:0] os_thrm;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sdm_mash #(.W(8), .ORDER_MAX(3)) dut (
    .nsh_clk               (clk),
    .nsh_rst_n             (rst_n),
    .s_os                  (s_os),
    .csr_flb_sdm_en        (en),
    .csr_flb_sdm_order     (ord),
    .csr_flb_sdm_thrm_en   (thrm),
    .csr_flb_sdm_dither_en (dith),
    .os_bin                (os_bin),
    .os_thrm               (os_thrm)
  );

  typedef struct packed {
    logic       en;
    logic [1:0] ord;
    logic       thrm;
    logic       dith;
    logic [7:0] s;
    logic [2:0] eb;
    logic [6:0] et;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic e, input logic [1:0] o, input logic t, input logic d,
                     input logic [7:0] s, input logic [2:0] eb, input logic [6:0] et);
    vec_t v;
    v.en = e; v.ord = o; v.thrm = t; v.dith = d; v.s = s; v.eb = eb; v.et = et;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic e, input logic [1:0] o, input logic t, input logic d,
                       input logic [7:0] s);
    en = e; ord = o; thrm = t; dith = d; s_os = s;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  int lv2[12] = '{1, 1, 1, 1, 2, 1, 1, 2, 1, 1, 1, 1};
  int n1d[6]  = '{0, 1, 0, 1, 1, 1};
  int n3[5]   = '{3, 3, 3, 3, 4};
  int rec[40];
  int sum;

  initial begin
    drive(1'b0, 2'd1, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b0;
    #12;
    chk("reset os_bin", int'(os_bin), 0);
    chk("reset os_thrm", int'(os_thrm), 0);
    chk("reset lfsr", int'(dut.lfsr_q), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // N=1, 0x80: first '1' on the 3rd enabled edge
    add(0, 2'd1, 0, 0, 8'h80, 3'd0, 7'h00);
    add(1, 2'd1, 0, 0, 8'h80, 3'd0, 7'h00);
    add(1, 2'd1, 0, 0, 8'h80, 3'd0, 7'h00);
    add(1, 2'd1, 0, 0, 8'h80, 3'd1, 7'h00);
    add(1, 2'd1, 0, 0, 8'h80, 3'd0, 7'h00);
    add(1, 2'd1, 0, 0, 8'h80, 3'd1, 7'h00);
    add(1, 2'd1, 0, 0, 8'h80, 3'd0, 7'h00);
    // order changes while running: OFF(new N) on the change edge, then s=0 keeps OFF
    add(1, 2'd2, 0, 0, 8'h00, 3'd1, 7'h00);
    add(1, 2'd2, 0, 0, 8'h00, 3'd1, 7'h00);
    add(1, 2'd2, 0, 0, 8'h00, 3'd1, 7'h00);
    add(1, 2'd3, 0, 0, 8'h00, 3'd3, 7'h00);
    add(1, 2'd3, 0, 0, 8'h00, 3'd3, 7'h00);
    add(1, 2'd3, 0, 0, 8'h00, 3'd3, 7'h00);
    add(1, 2'd0, 0, 0, 8'h00, 3'd0, 7'h00);
    add(1, 2'd0, 0, 0, 8'h00, 3'd0, 7'h00);
    add(1, 2'd2, 1, 0, 8'h00, 3'd0, 7'h01);
    add(1, 2'd2, 1, 0, 8'h00, 3'd0, 7'h01);
    add(1, 2'd2, 0, 0, 8'h00, 3'd1, 7'h00);
    add(1, 2'd3, 1, 0, 8'h00, 3'd0, 7'h07);
    // N=2, 0x40, thermometer from a cleared state
    add(0, 2'd2, 1, 0, 8'h40, 3'd0, 7'h00);
    for (int i = 0; i < 12; i++) begin
      add(1, 2'd2, 1, 0, 8'h40, 3'd0, (lv2[i] == 1) ? 7'h01 : 7'h03);
    end
    // N=1, 0xFF, dither: seed bit 0 injects a carry on the first edge
    add(0, 2'd1, 0, 1, 8'hFF, 3'd0, 7'h00);
    for (int i = 0; i < 6; i++) begin
      add(1, 2'd1, 0, 1, 8'hFF, 3'(n1d[i]), 7'h00);
    end
    // N=3, 0x40 from cleared state
    add(0, 2'd3, 0, 0, 8'h40, 3'd0, 7'h00);
    for (int i = 0; i < 5; i++) begin
      add(1, 2'd3, 0, 0, 8'h40, 3'(n3[i]), 7'h00);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].ord, tbl[i].thrm, tbl[i].dith, tbl[i].s);
      tick();
      chk($sformatf("vec%0d os_bin", i), int'(os_bin), int'(tbl[i].eb));
      chk($sformatf("vec%0d os_thrm", i), int'(os_thrm), int'(tbl[i].et));
    end

    // N=3, 0x40 keeps running: mean over 1024 cycles must be 3.25 +/- 4/256
    sum = 0;
    for (int i = 0; i < 1024; i++) begin
      tick();
      sum += int'(os_bin);
      if (os_thrm != 7'h00) chk($sformatf("n3 os_thrm cyc%0d", i), int'(os_thrm), 0);
    end
    n_vec++;
    if (sum < 3312 || sum > 3344) begin
      n_err++;
      $display("FAIL n3 mean: sum %0d over 1024, expected 3312..3344", sum);
    end

    // N=1, 0x80: alternation from the 3rd edge, mean 0.5 over 256 cycles
    drive(1'b0, 2'd1, 1'b0, 1'b0, 8'h80);
    tick();
    drive(1'b1, 2'd1, 1'b0, 1'b0, 8'h80);
    tick();
    chk("n1 edge1", int'(os_bin), 0);
    tick();
    chk("n1 edge2", int'(os_bin), 0);
    sum = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      sum += int'(os_bin);
      if (int'(os_bin) != ((i % 2 == 0) ? 1 : 0)) begin
        chk($sformatf("n1 alt cyc%0d", i), int'(os_bin), (i % 2 == 0) ? 1 : 0);
      end
    end
    chk("n1 sum256", sum, 128);

    // order 2 -> 3 mid-run: OFF(3) on the change edge, then a fresh N=3 run
    drive(1'b0, 2'd2, 1'b0, 1'b0, 8'h40);
    tick();
    drive(1'b1, 2'd2, 1'b0, 1'b0, 8'h40);
    repeat (10) tick();
    drive(1'b1, 2'd3, 1'b0, 1'b0, 8'h40);
    tick();
    chk("switch edge", int'(os_bin), 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("after switch %0d", i), int'(os_bin), n3[i]);
    end

    // asynchronous reset in mid-cycle
    drive(1'b0, 2'd3, 1'b0, 1'b0, 8'h00);
    tick();
    drive(1'b1, 2'd3, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    chk("pre-reset", int'(os_bin), 3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst os_bin", int'(os_bin), 0);
    chk("async rst os_thrm", int'(os_thrm), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("first edge after rst", int'(os_bin), 3);

    // enable drop reseeds the LFSR: dithered sequence repeats exactly
    drive(1'b0, 2'd1, 1'b0, 1'b1, 8'hFF);
    tick();
    chk("lfsr seed idle", int'(dut.lfsr_q), 1);
    drive(1'b1, 2'd1, 1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 40; i++) begin
      tick();
      rec[i] = int'(os_bin);
    end
    drive(1'b0, 2'd1, 1'b0, 1'b1, 8'hFF);
    tick();
    chk("en drop os_bin", int'(os_bin), 0);
    chk("en drop lfsr", int'(dut.lfsr_q), 1);
    drive(1'b1, 2'd1, 1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i < 6) begin
        chk($sformatf("dither rerun hand %0d", i), int'(os_bin), n1d[i]);
      end else if (int'(os_bin) != rec[i]) begin
        chk($sformatf("dither rerun %0d", i), int'(os_bin), rec[i]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
